// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch
// Description : Program counter and IF/ID fetch register with stall, branch
//               redirect (absolute / PC-relative) and halt handling.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [A-1:0] start_addr,
  input  logic         stall,
  input  logic         branch_en,
  input  logic         branch_rel,
  input  logic [A-1:0] branch_target,
  input  logic [7:0]   branch_offset,
  input  logic         halt_req,
  output logic [A-1:0] instr_address,
  input  logic [W-1:0] instr_in,
  output logic [W-1:0] instr_out,
  output logic [A-1:0] instr_pc,
  output logic         instr_valid,
  output logic         done
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_fetch = 2'd1;
  localparam logic [1:0] c_halt  = 2'd2;

  logic [1:0]   r_state, w_state_nxt;
  logic [A-1:0] r_pc, w_pc_nxt;
  logic [W-1:0] r_instr_out, w_instr_out_nxt;
  logic [A-1:0] r_instr_pc, w_instr_pc_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_done, w_done_nxt;

  logic         w_halt_take;
  logic         w_branch_take;
  logic [A-1:0] w_rel_target;

  // Decode requests only refer to a live instruction in the IF/ID register
  assign w_halt_take   = r_valid && halt_req;
  assign w_branch_take = r_valid && branch_en && !halt_req;
  assign w_rel_target  = r_instr_pc + A'($signed(branch_offset));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_pc        <= '0;
      r_instr_out <= '0;
      r_instr_pc  <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else if (!stall) begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_instr_out <= w_instr_out_nxt;
      r_instr_pc  <= w_instr_pc_nxt;
      r_valid     <= w_valid_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (start) w_state_nxt = c_fetch;
      c_fetch: if (w_halt_take) w_state_nxt = c_halt;
      c_halt:  if (start) w_state_nxt = c_fetch;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_pc_nxt        = r_pc;
    w_instr_out_nxt = r_instr_out;
    w_instr_pc_nxt  = r_instr_pc;
    w_valid_nxt     = 1'b0;
    w_done_nxt      = r_done;
    case (r_state)
      c_idle: begin
        if (start) w_pc_nxt = start_addr;
      end
      c_fetch: begin
        if (w_halt_take) begin
          w_done_nxt = 1'b1;
        end else if (w_branch_take) begin
          // Squash the sequential fetch; target shows up one cycle later
          w_pc_nxt = branch_rel ? w_rel_target : branch_target;
        end else begin
          w_instr_out_nxt = instr_in;
          w_instr_pc_nxt  = r_pc;
          w_valid_nxt     = 1'b1;
          w_pc_nxt        = r_pc + A'(1);
        end
      end
      c_halt: begin
        w_done_nxt = 1'b1;
        if (start) begin
          w_pc_nxt   = start_addr;
          w_done_nxt = 1'b0;
        end
      end
      default: begin
        w_pc_nxt   = '0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  assign instr_address = r_pc;
  assign instr_out     = r_instr_out;
  assign instr_pc      = r_instr_pc;
  assign instr_valid   = r_valid;
  assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch
// Description : Directed self-checking bench for pc_fetch with a ROM whose
//               word equals the low address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

  localparam int A = 10;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [A-1:0] start_addr = '0;
  logic         stall = 1'b0;
  logic         branch_en = 1'b0;
  logic         branch_rel = 1'b0;
  logic [A-1:0] branch_target = '0;
  logic [7:0]   branch_offset = '0;
  logic         halt_req = 1'b0;
  logic [A-1:0] instr_address;
  logic [W-1:0] instr_in;
  logic [W-1:0] instr_out;
  logic [A-1:0] instr_pc;
  logic         instr_valid;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch #(.A(A), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .stall(stall), .branch_en(branch_en), .branch_rel(branch_rel),
    .branch_target(branch_target), .branch_offset(branch_offset),
    .halt_req(halt_req), .instr_address(instr_address), .instr_in(instr_in),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .done(done)
  );

  assign instr_in = instr_address[8:0];

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the whole visible fetch state in one go
  task automatic check_all(input string tag, input logic [A-1:0] pc, input logic [A-1:0] ipc,
                           input logic v, input logic d);
    check_eq({tag, ".addr"},  32'(instr_address), 32'(pc));
    check_eq({tag, ".ipc"},   32'(instr_pc), 32'(ipc));
    check_eq({tag, ".valid"}, 32'(instr_valid), 32'(v));
    check_eq({tag, ".done"},  32'(done), 32'(d));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check_all("rst", 10'h000, 10'h000, 1'b0, 1'b0);
    check_eq("rst.iout", 32'(instr_out), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_all("idle_hold", 10'h000, 10'h000, 1'b0, 1'b0);

    // Sequential fetch from 0x010
    start = 1'b1; start_addr = 10'h010;
    tick();
    start = 1'b0;
    check_all("seq0", 10'h010, 10'h000, 1'b0, 1'b0);
    tick();
    check_all("seq1", 10'h011, 10'h010, 1'b1, 1'b0);
    check_eq("seq1.iout", 32'(instr_out), 32'h010);
    tick();
    check_all("seq2", 10'h012, 10'h011, 1'b1, 1'b0);
    check_eq("seq2.iout", 32'(instr_out), 32'h011);

    // start in FETCH ignored
    start = 1'b1; start_addr = 10'h200;
    tick();
    start = 1'b0;
    check_all("fetch_start", 10'h013, 10'h012, 1'b1, 1'b0);

    // Halt, then restart at 0x01F to reach instr_pc 0x020
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_all("halt1", 10'h013, 10'h012, 1'b0, 1'b1);
    start = 1'b1; start_addr = 10'h01F;
    tick();
    start = 1'b0;
    check_all("restart1", 10'h01F, 10'h012, 1'b0, 1'b0);
    tick(); tick();
    check_all("at020a", 10'h021, 10'h020, 1'b1, 1'b0);

    // Relative branch -4
    branch_en = 1'b1; branch_rel = 1'b1; branch_offset = 8'hFC;
    tick();
    branch_en = 1'b0;
    check_all("brm4_sq", 10'h01C, 10'h020, 1'b0, 1'b0);
    tick();
    check_all("brm4_tg", 10'h01D, 10'h01C, 1'b1, 1'b0);
    check_eq("brm4.iout", 32'(instr_out), 32'h01C);
    tick(); tick(); tick(); tick();
    check_all("at020b", 10'h021, 10'h020, 1'b1, 1'b0);

    // Relative branch +127
    branch_en = 1'b1; branch_rel = 1'b1; branch_offset = 8'h7F;
    tick();
    branch_en = 1'b0;
    check_all("br7f_sq", 10'h09F, 10'h020, 1'b0, 1'b0);
    tick();
    check_all("br7f_tg", 10'h0A0, 10'h09F, 1'b1, 1'b0);

    // Absolute branch held off by a 2-cycle stall
    branch_en = 1'b1; branch_rel = 1'b0; branch_target = 10'h100; stall = 1'b1;
    tick();
    check_all("stall1", 10'h0A0, 10'h09F, 1'b1, 1'b0);
    tick();
    check_all("stall2", 10'h0A0, 10'h09F, 1'b1, 1'b0);
    stall = 1'b0;
    tick();
    branch_en = 1'b0;
    check_all("abs_sq", 10'h100, 10'h09F, 1'b0, 1'b0);
    tick();
    check_all("abs_tg", 10'h101, 10'h100, 1'b1, 1'b0);

    // Halt wins over simultaneous branch
    halt_req = 1'b1; branch_en = 1'b1; branch_target = 10'h155;
    tick();
    halt_req = 1'b0;
    check_all("halt_br", 10'h101, 10'h100, 1'b0, 1'b1);
    tick();
    branch_en = 1'b0;
    check_all("halt_stay", 10'h101, 10'h100, 1'b0, 1'b1);

    // Stall outranks start in HALT
    stall = 1'b1; start = 1'b1; start_addr = 10'h040;
    tick();
    check_all("halt_stall", 10'h101, 10'h100, 1'b0, 1'b1);
    stall = 1'b0;
    tick();
    start = 1'b0;
    check_all("restart40", 10'h040, 10'h100, 1'b0, 1'b0);
    tick();
    check_all("fetch40", 10'h041, 10'h040, 1'b1, 1'b0);

    // Wrap at top of address space; halt_req ignored while instr_valid=0
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    start = 1'b1; start_addr = 10'h3FE;
    tick();
    start = 1'b0; halt_req = 1'b1;
    check_all("wrap0", 10'h3FE, 10'h040, 1'b0, 1'b0);
    tick();
    halt_req = 1'b0;
    check_all("wrap1", 10'h3FF, 10'h3FE, 1'b1, 1'b0);
    tick();
    check_all("wrap2", 10'h000, 10'h3FF, 1'b1, 1'b0);
    tick();
    check_all("wrap3", 10'h001, 10'h000, 1'b1, 1'b0);

    // Asynchronous reset mid-FETCH
    #2 rst_n = 1'b0;
    #1;
    check_all("arst", 10'h000, 10'h000, 1'b0, 1'b0);
    check_eq("arst.iout", 32'(instr_out), 32'h0);
    start = 1'b1; start_addr = 10'h0AA;
    rst_n = 1'b1;
    #0.5;
    check_eq("arst_prestart", 32'(instr_address), 32'h000);
    tick();
    start = 1'b0;
    check_all("arst_start", 10'h0AA, 10'h000, 1'b0, 1'b0);
    tick();
    check_all("arst_fetch", 10'h0AB, 10'h0AA, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter A, default 10: instruction address width in bits.
REQ-002 SHALL have parameter W, default 9: instruction width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin program execution at start_addr.
REQ-006 SHALL have port start_addr, input, A: first instruction address.
REQ-007 SHALL have port stall, input, 1: freezes all fetch state for the cycle.
REQ-008 SHALL have port branch_en, input, 1: redirect request from decode for the current instr_out.
REQ-009 SHALL have port branch_rel, input, 1: 1 selects relative target, 0 selects absolute target.
REQ-010 SHALL have port branch_target, input, A: absolute target address.
REQ-011 SHALL have port branch_offset, input, 8: signed two's-complement relative offset.
REQ-012 SHALL have port halt_req, input, 1: decode reports that instr_out is a halt instruction.
REQ-013 SHALL have port instr_address, output, A: address driven to the combinational instruction ROM; it equals pc.
REQ-014 SHALL have port instr_in, input, W: ROM data for instr_address, valid in the same cycle.
REQ-015 SHALL have port instr_out, output, W: registered fetched instruction (IF/ID register).
REQ-016 SHALL have port instr_pc, output, A: address from which instr_out was fetched.
REQ-017 SHALL have port instr_valid, output, 1: instr_out holds a live, non-squashed instruction.
REQ-018 SHALL have port done, output, 1: program has halted.

Function
REQ-019 SHALL implement three states: IDLE, FETCH, HALT.
REQ-020 IDLE: on start=1, SHALL load pc<=start_addr and enter FETCH; instr_valid SHALL remain 0 that cycle.
REQ-021 In FETCH with stall=0 and no branch or halt, each cycle SHALL capture instr_out<=instr_in, instr_pc<=pc, instr_valid<=1, and pc<=pc+1.
REQ-022 pc arithmetic SHALL be modulo 2^A, so 2^A-1 wraps to 0.
REQ-023 stall=1 in any state SHALL hold pc, state, instr_out, instr_pc, instr_valid and done unchanged; stall outranks start, branch and halt.
REQ-024 branch_en and halt_req SHALL be honoured only when instr_valid=1; otherwise they are ignored.
REQ-025 Branch in FETCH: pc SHALL load branch_target if branch_rel=0, else instr_pc+sext(branch_offset) mod 2^A.
REQ-026 Branch in FETCH: instr_valid SHALL go 0 on the same edge to squash the sequential fetch, giving a one-cycle penalty; the target instruction appears valid one cycle later.
REQ-027 Halt in FETCH: on halt_req, SHALL enter HALT, set instr_valid<=0 and done<=1, and leave pc unchanged.
REQ-028 halt_req and branch_en asserted together: halt SHALL win.
REQ-029 start while in FETCH SHALL be ignored.
REQ-030 HALT: done SHALL stay 1 and instr_valid 0; start=1 SHALL load pc<=start_addr, clear done, and enter FETCH.
REQ-031 instr_address SHALL be driven combinationally from pc only, with no path from instr_in.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, pc=0, instr_out=0, instr_pc=0, instr_valid=0 and done=0, at any time including mid-FETCH or mid-stall.
REQ-033 After rst_n deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-034 Reset, then start with start_addr=0x010, no stall; ROM word=addr[8:0] -> instr_address 0x010,0x011,0x012 on successive cycles; instr_out/instr_pc trail by one cycle; instr_valid=1 from the second cycle.
REQ-035 Start at 0x3FE -> instr_pc sequence 0x3FE, 0x3FF, 0x000.
REQ-036 Branch with instr_pc=0x020 and branch_rel=1: offset -4 -> next valid instr_pc=0x01C; offset=0x7F -> 0x09F; one squashed cycle (instr_valid=0) in each case.
REQ-037 Absolute branch to 0x100 asserted together with stall=1 for 2 cycles -> no state change while stalled; redirect occurs on the first unstalled edge.
REQ-038 halt_req and branch_en asserted in the same cycle -> done=1 next cycle, pc not redirected; start with start_addr=0x040 -> done=0, fetch resumes at 0x040.
REQ-039 rst_n pulsed low asynchronously mid-FETCH -> all outputs 0 before the next clock edge; start before the first edge after deassertion has no effect until clocked in IDLE.
